mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-002 ex_valid_in in 1, EX holds a valid instruction; mem_allowin_out out 1, MEM accepts this cycle.
REQ-003 ex_PC_in in 32, ex_wnum_in in 5, ex_sel_wbdata_in in 3, ex_onehot_in in 8, ex_lubhw_con_in in 5, ex_write_type_in in 3, ex_llr_we_in in 4, ex_ExcCode_in in 5, ex_exception_in in 1: payload captured from EX.
REQ-004 ex_wbdata_in in 32, ALU result or memory address; ex_memop_in in 2, {store,load}, 00 = no access; ex_wstrb_in in 4, store byte strobes; ex_store_data_in in 32, aligned store data.
REQ-005 wb_allowin_in in 1, WB accepts; wb_ClrStpJmp_in in 1, flush from WB (exception/eret).
REQ-006 mem_valid_out out 1; mem_PC_out, mem_wnum_out, mem_sel_wbdata_out, mem_onehot_out, mem_lubhw_con_out, mem_write_type_out, mem_wbdata_out, mem_llr_we_out, mem_exception_out, mem_ExcCode_out out, widths as REQ-003/004: registered payload to WB.
REQ-007 mem_dm_data_out out 32, buffered load data; mem_adrl_out out 2, address bits [1:0].
REQ-008 data_req out 1, data_wr out 1, data_wstrb out 4, data_addr out 32, data_wdata out 32: memory request; data_addr_ok in 1, data_data_ok in 1, data_rdata in 32: memory responses.

Function
REQ-009 Handshake: allowin = (state!=CANCEL) && (!valid_r || (ready && wb_allowin_in)); mem_valid_out = valid_r && ready.
REQ-010 On clk with allowin: valid_r <= ex_valid_in && !wb_ClrStpJmp_in; payload captured only when ex_valid_in; otherwise payload holds.
REQ-011 wb_ClrStpJmp_in SHALL clear valid_r on the next edge regardless of allowin.
REQ-012 ready = 1 when valid_r and (memop==00 or exception_r); else ready = (state==DONE).
REQ-013 States: IDLE, WAIT, DONE, CANCEL; one outstanding transaction max.
REQ-014 data_req = (state==IDLE) && valid_r && memop!=00 && !exception_r && !wb_ClrStpJmp_in; combinational; data_wr = memop[1]; data_addr = wbdata_r; data_wstrb = wstrb_r for stores, 4'b0000 for loads; data_wdata = store_data_r.
REQ-015 IDLE -> WAIT on data_req && data_addr_ok; flush with req low issues nothing.
REQ-016 WAIT: data_data_ok && !flush -> DONE, rdata_r <= data_rdata (loads; stores leave rdata_r); data_data_ok && flush -> IDLE, discarded; !data_data_ok && flush -> CANCEL.
REQ-017 DONE: wb_allowin_in or flush -> IDLE; else hold DONE and rdata_r.
REQ-018 CANCEL: mem_allowin_out=0, data_req=0; data_data_ok -> IDLE, data discarded.
REQ-019 data_data_ok is never earlier than the cycle after the accepting data_addr_ok; data_data_ok in IDLE or DONE SHALL be ignored.
REQ-020 mem_dm_data_out = rdata_r; mem_adrl_out = wbdata_r[1:0]; other outputs direct from pipeline registers.
REQ-021 Minimum load latency: accepted at edge N, addr_ok in cycle N, data_ok in N+1, mem_valid_out=1 in N+2; non-memory instructions valid the cycle after capture.

Reset
REQ-022 With rst_n=0 at an edge: valid_r=0, state=IDLE, all payload registers and rdata_r = 0; outputs then mem_valid_out=0, data_req=0, mem_allowin_out=1, all data outputs 0.
REQ-023 Reset mid-transaction SHALL return to IDLE; a data_data_ok for the abandoned request SHALL be ignored.

Verification
REQ-024 ALU op (memop=00, wbdata=0x1234), wb_allowin_in=1 -> mem_valid_out=1 next cycle, mem_wbdata_out=0x1234, data_req never 1.
REQ-025 Load addr 0x80001006, addr_ok same cycle, data_ok+rdata=0xDEADBEEF next cycle -> mem_valid_out=1 two cycles after capture, mem_dm_data_out=0xDEADBEEF, mem_adrl_out=2'b10.
REQ-026 Load completes with wb_allowin_in=0 for 3 cycles -> state DONE held, mem_dm_data_out stable, mem_allowin_out=0, and it leaves on the first wb_allowin_in=1.
REQ-027 Store issued, flush in WAIT, data_ok 2 cycles later -> CANCEL, mem_allowin_out=0 until data_ok, then IDLE, mem_valid_out never 1.
REQ-028 Load with ex_exception_in=1, ExcCode=5'h04 -> data_req stays 0, mem_valid_out=1 next cycle, mem_exception_out=1, mem_ExcCode_out=5'h04.
REQ-029 rst_n=0 in WAIT, data_ok arrives after release -> state IDLE, response ignored, mem_valid_out=0.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: latches EX payload, issues one data-memory request, buffers load data for WB.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_in,
  output logic        mem_allowin_out,
  input  logic [31:0] ex_PC_in,
  input  logic [4:0]  ex_wnum_in,
  input  logic [2:0]  ex_sel_wbdata_in,
  input  logic [7:0]  ex_onehot_in,
  input  logic [4:0]  ex_lubhw_con_in,
  input  logic [2:0]  ex_write_type_in,
  input  logic [3:0]  ex_llr_we_in,
  input  logic [4:0]  ex_ExcCode_in,
  input  logic        ex_exception_in,
  input  logic [31:0] ex_wbdata_in,
  input  logic [1:0]  ex_memop_in,
  input  logic [3:0]  ex_wstrb_in,
  input  logic [31:0] ex_store_data_in,
  input  logic        wb_allowin_in,
  input  logic        wb_ClrStpJmp_in,
  output logic        mem_valid_out,
  output logic [31:0] mem_PC_out,
  output logic [4:0]  mem_wnum_out,
  output logic [2:0]  mem_sel_wbdata_out,
  output logic [7:0]  mem_onehot_out,
  output logic [4:0]  mem_lubhw_con_out,
  output logic [2:0]  mem_write_type_out,
  output logic [31:0] mem_wbdata_out,
  output logic [3:0]  mem_llr_we_out,
  output logic        mem_exception_out,
  output logic [4:0]  mem_ExcCode_out,
  output logic [31:0] mem_dm_data_out,
  output logic [1:0]  mem_adrl_out,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t      r_state;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_wnum;
  logic [2:0]  r_sel_wbdata;
  logic [7:0]  r_onehot;
  logic [4:0]  r_lubhw_con;
  logic [2:0]  r_write_type;
  logic [3:0]  r_llr_we;
  logic [4:0]  r_exccode;
  logic        r_exception;
  logic [31:0] r_wbdata;
  logic [1:0]  r_memop;
  logic [3:0]  r_wstrb;
  logic [31:0] r_store_data;
  logic [31:0] r_rdata;

  logic w_flush;
  logic w_ready;
  logic w_allowin;
  logic w_req;

  assign w_flush   = wb_ClrStpJmp_in;
  // Excepting instructions never touch memory, so they are ready immediately like ALU ops.
  assign w_ready   = (r_valid && (r_memop == 2'b00 || r_exception)) ? 1'b1 : (r_state == S_DONE);
  assign w_allowin = (r_state != S_CANCEL) && (!r_valid || (w_ready && wb_allowin_in));
  assign w_req     = (r_state == S_IDLE) && r_valid && (r_memop != 2'b00) && !r_exception && !w_flush;

  assign mem_allowin_out = w_allowin;
  assign mem_valid_out   = r_valid && w_ready;

  assign data_req   = w_req;
  assign data_wr    = r_memop[1];
  assign data_addr  = r_wbdata;
  assign data_wstrb = r_memop[1] ? r_wstrb : 4'b0000;
  assign data_wdata = r_store_data;

  assign mem_PC_out         = r_pc;
  assign mem_wnum_out       = r_wnum;
  assign mem_sel_wbdata_out = r_sel_wbdata;
  assign mem_onehot_out     = r_onehot;
  assign mem_lubhw_con_out  = r_lubhw_con;
  assign mem_write_type_out = r_write_type;
  assign mem_wbdata_out     = r_wbdata;
  assign mem_llr_we_out     = r_llr_we;
  assign mem_exception_out  = r_exception;
  assign mem_ExcCode_out    = r_exccode;
  assign mem_dm_data_out    = r_rdata;
  assign mem_adrl_out       = r_wbdata[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_pc         <= 32'd0;
      r_wnum       <= 5'd0;
      r_sel_wbdata <= 3'd0;
      r_onehot     <= 8'd0;
      r_lubhw_con  <= 5'd0;
      r_write_type <= 3'd0;
      r_llr_we     <= 4'd0;
      r_exccode    <= 5'd0;
      r_exception  <= 1'b0;
      r_wbdata     <= 32'd0;
      r_memop      <= 2'd0;
      r_wstrb      <= 4'd0;
      r_store_data <= 32'd0;
      r_rdata      <= 32'd0;
    end else begin
      if (w_flush)
        r_valid <= 1'b0;
      else if (w_allowin)
        r_valid <= ex_valid_in;

      if (w_allowin && ex_valid_in) begin
        r_pc         <= ex_PC_in;
        r_wnum       <= ex_wnum_in;
        r_sel_wbdata <= ex_sel_wbdata_in;
        r_onehot     <= ex_onehot_in;
        r_lubhw_con  <= ex_lubhw_con_in;
        r_write_type <= ex_write_type_in;
        r_llr_we     <= ex_llr_we_in;
        r_exccode    <= ex_ExcCode_in;
        r_exception  <= ex_exception_in;
        r_wbdata     <= ex_wbdata_in;
        r_memop      <= ex_memop_in;
        r_wstrb      <= ex_wstrb_in;
        r_store_data <= ex_store_data_in;
      end

      // CANCEL drains the response of a flushed request so it cannot be mistaken for a later one.
      case (r_state)
        S_IDLE: begin
          if (w_req && data_addr_ok)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (data_data_ok) begin
            if (w_flush) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DONE;
              if (r_memop[0])
                r_rdata <= data_rdata;
            end
          end else if (w_flush) begin
            r_state <= S_CANCEL;
          end
        end
        S_DONE: begin
          if (wb_allowin_in || w_flush)
            r_state <= S_IDLE;
        end
        S_CANCEL: begin
          if (data_data_ok)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_in;
  logic        mem_allowin_out;
  logic [31:0] ex_PC_in;
  logic [4:0]  ex_wnum_in;
  logic [2:0]  ex_sel_wbdata_in;
  logic [7:0]  ex_onehot_in;
  logic [4:0]  ex_lubhw_con_in;
  logic [2:0]  ex_write_type_in;
  logic [3:0]  ex_llr_we_in;
  logic [4:0]  ex_ExcCode_in;
  logic        ex_exception_in;
  logic [31:0] ex_wbdata_in;
  logic [1:0]  ex_memop_in;
  logic [3:0]  ex_wstrb_in;
  logic [31:0] ex_store_data_in;
  logic        wb_allowin_in;
  logic        wb_ClrStpJmp_in;
  logic        mem_valid_out;
  logic [31:0] mem_PC_out;
  logic [4:0]  mem_wnum_out;
  logic [2:0]  mem_sel_wbdata_out;
  logic [7:0]  mem_onehot_out;
  logic [4:0]  mem_lubhw_con_out;
  logic [2:0]  mem_write_type_out;
  logic [31:0] mem_wbdata_out;
  logic [3:0]  mem_llr_we_out;
  logic        mem_exception_out;
  logic [4:0]  mem_ExcCode_out;
  logic [31:0] mem_dm_data_out;
  logic [1:0]  mem_adrl_out;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int vecs = 0;
  int errs = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_in(ex_valid_in), .mem_allowin_out(mem_allowin_out),
    .ex_PC_in(ex_PC_in), .ex_wnum_in(ex_wnum_in), .ex_sel_wbdata_in(ex_sel_wbdata_in),
    .ex_onehot_in(ex_onehot_in), .ex_lubhw_con_in(ex_lubhw_con_in),
    .ex_write_type_in(ex_write_type_in), .ex_llr_we_in(ex_llr_we_in),
    .ex_ExcCode_in(ex_ExcCode_in), .ex_exception_in(ex_exception_in),
    .ex_wbdata_in(ex_wbdata_in), .ex_memop_in(ex_memop_in), .ex_wstrb_in(ex_wstrb_in),
    .ex_store_data_in(ex_store_data_in),
    .wb_allowin_in(wb_allowin_in), .wb_ClrStpJmp_in(wb_ClrStpJmp_in),
    .mem_valid_out(mem_valid_out), .mem_PC_out(mem_PC_out), .mem_wnum_out(mem_wnum_out),
    .mem_sel_wbdata_out(mem_sel_wbdata_out), .mem_onehot_out(mem_onehot_out),
    .mem_lubhw_con_out(mem_lubhw_con_out), .mem_write_type_out(mem_write_type_out),
    .mem_wbdata_out(mem_wbdata_out), .mem_llr_we_out(mem_llr_we_out),
    .mem_exception_out(mem_exception_out), .mem_ExcCode_out(mem_ExcCode_out),
    .mem_dm_data_out(mem_dm_data_out), .mem_adrl_out(mem_adrl_out),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid_in = 0; ex_PC_in = 0; ex_wnum_in = 0; ex_sel_wbdata_in = 0;
    ex_onehot_in = 0; ex_lubhw_con_in = 0; ex_write_type_in = 0; ex_llr_we_in = 0;
    ex_ExcCode_in = 0; ex_exception_in = 0; ex_wbdata_in = 0; ex_memop_in = 0;
    ex_wstrb_in = 0; ex_store_data_in = 0;
    wb_allowin_in = 1; wb_ClrStpJmp_in = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    vecs++;
    if (mem_valid_out !== 1'b0 || data_req !== 1'b0 || mem_allowin_out !== 1'b1) begin
      errs++;
      $display("FAIL reset_ctrl: valid=%b req=%b allowin=%b, need 0 0 1", mem_valid_out, data_req, mem_allowin_out);
    end
    vecs++;
    if (data_addr !== 0 || data_wdata !== 0 || data_wstrb !== 0 || data_wr !== 0 ||
        mem_dm_data_out !== 0 || mem_PC_out !== 0 || mem_wbdata_out !== 0) begin
      errs++;
      $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h wr=%b dm=%h pc=%h wbd=%h, need all 0",
               data_addr, data_wdata, data_wstrb, data_wr, mem_dm_data_out, mem_PC_out, mem_wbdata_out);
    end
    rst_n = 1;
  endtask

  task automatic test_alu();
    ex_valid_in = 1; ex_memop_in = 2'b00; ex_wbdata_in = 32'h1234;
    ex_PC_in = 32'hBFC0_0000; ex_wnum_in = 5'd3; ex_onehot_in = 8'h21;
    #1;
    vecs++;
    if (mem_allowin_out !== 1'b1) begin
      errs++; $display("FAIL alu_allowin: got %b need 1", mem_allowin_out);
    end
    step();
    ex_valid_in = 0;
    #1;
    vecs++;
    if (mem_valid_out !== 1'b1 || mem_wbdata_out !== 32'h1234 || mem_PC_out !== 32'hBFC0_0000 ||
        mem_wnum_out !== 5'd3 || mem_onehot_out !== 8'h21 || data_req !== 1'b0) begin
      errs++;
      $display("FAIL alu_out: valid=%b wbd=%h pc=%h wnum=%0d oh=%h req=%b, need 1 1234 bfc00000 3 21 0",
               mem_valid_out, mem_wbdata_out, mem_PC_out, mem_wnum_out, mem_onehot_out, data_req);
    end
    step();
    vecs++;
    if (mem_valid_out !== 1'b0 || data_req !== 1'b0) begin
      errs++; $display("FAIL alu_drain: valid=%b req=%b need 0 0", mem_valid_out, data_req);
    end
  endtask

  task automatic test_load();
    ex_valid_in = 1; ex_memop_in = 2'b01; ex_wbdata_in = 32'h8000_1006; ex_wstrb_in = 4'hF;
    step();
    ex_valid_in = 0;
    data_addr_ok = 1;
    #1;
    vecs++;
    if (data_req !== 1'b1 || data_addr !== 32'h8000_1006 || data_wr !== 1'b0 ||
        data_wstrb !== 4'b0000 || mem_valid_out !== 1'b0 || mem_allowin_out !== 1'b0) begin
      errs++;
      $display("FAIL load_req: req=%b addr=%h wr=%b wstrb=%h valid=%b allowin=%b, need 1 80001006 0 0 0 0",
               data_req, data_addr, data_wr, data_wstrb, mem_valid_out, mem_allowin_out);
    end
    step();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    #1;
    vecs++;
    if (data_req !== 1'b0 || mem_valid_out !== 1'b0) begin
      errs++; $display("FAIL load_wait: req=%b valid=%b need 0 0", data_req, mem_valid_out);
    end
    step();
    data_data_ok = 0; data_rdata = 0;
    #1;
    vecs++;
    if (mem_valid_out !== 1'b1 || mem_dm_data_out !== 32'hDEAD_BEEF || mem_adrl_out !== 2'b10 ||
        mem_allowin_out !== 1'b1) begin
      errs++;
      $display("FAIL load_done: valid=%b dm=%h adrl=%b allowin=%b, need 1 deadbeef 10 1",
               mem_valid_out, mem_dm_data_out, mem_adrl_out, mem_allowin_out);
    end
    step();
    vecs++;
    if (mem_valid_out !== 1'b0 || data_req !== 1'b0) begin
      errs++; $display("FAIL load_drain: valid=%b req=%b need 0 0", mem_valid_out, data_req);
    end
  endtask

  task automatic test_load_stall();
    ex_valid_in = 1; ex_memop_in = 2'b01; ex_wbdata_in = 32'h0000_0010;
    step();
    ex_valid_in = 0; data_addr_ok = 1;
    step();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE_F00D; wb_allowin_in = 0;
    step();
    data_data_ok = 0; data_rdata = 0;
    // A new EX instruction waits; a stray data_ok in DONE must be ignored.
    ex_valid_in = 1; ex_memop_in = 2'b00; ex_wbdata_in = 32'h0000_9999;
    for (int i = 0; i < 3; i++) begin
      data_data_ok = (i == 1); data_rdata = (i == 1) ? 32'h1111_1111 : 32'h0;
      #1;
      vecs++;
      if (mem_valid_out !== 1'b1 || mem_dm_data_out !== 32'hCAFE_F00D || mem_allowin_out !== 1'b0 ||
          mem_wbdata_out !== 32'h0000_0010 || mem_adrl_out !== 2'b00) begin
        errs++;
        $display("FAIL stall_hold[%0d]: valid=%b dm=%h allowin=%b wbd=%h adrl=%b, need 1 cafef00d 0 00000010 00",
                 i, mem_valid_out, mem_dm_data_out, mem_allowin_out, mem_wbdata_out, mem_adrl_out);
      end
      step();
    end
    data_data_ok = 0; data_rdata = 0;
    wb_allowin_in = 1;
    #1;
    vecs++;
    if (mem_allowin_out !== 1'b1) begin
      errs++; $display("FAIL stall_release: allowin=%b need 1", mem_allowin_out);
    end
    step();
    ex_valid_in = 0;
    #1;
    vecs++;
    if (mem_valid_out !== 1'b1 || mem_wbdata_out !== 32'h0000_9999 || data_req !== 1'b0) begin
      errs++;
      $display("FAIL stall_next: valid=%b wbd=%h req=%b, need 1 00009999 0", mem_valid_out, mem_wbdata_out, data_req);
    end
    step();
  endtask

  task automatic test_store_cancel();
    ex_valid_in = 1; ex_memop_in = 2'b10; ex_wbdata_in = 32'h0000_0104;
    ex_wstrb_in = 4'b0011; ex_store_data_in = 32'h0000_ABCD;
    step();
    ex_valid_in = 0; data_addr_ok = 1;
    #1;
    vecs++;
    if (data_req !== 1'b1 || data_wr !== 1'b1 || data_wstrb !== 4'b0011 ||
        data_wdata !== 32'h0000_ABCD || data_addr !== 32'h0000_0104) begin
      errs++;
      $display("FAIL store_req: req=%b wr=%b wstrb=%b wdata=%h addr=%h, need 1 1 0011 0000abcd 00000104",
               data_req, data_wr, data_wstrb, data_wdata, data_addr);
    end
    step();
    data_addr_ok = 0; wb_ClrStpJmp_in = 1;
    #1;
    vecs++;
    if (data_req !== 1'b0 || mem_valid_out !== 1'b0) begin
      errs++; $display("FAIL store_flush: req=%b valid=%b need 0 0", data_req, mem_valid_out);
    end
    step();
    wb_ClrStpJmp_in = 0;
    for (int i = 0; i < 2; i++) begin
      data_data_ok = (i == 1);
      #1;
      vecs++;
      if (mem_allowin_out !== 1'b0 || data_req !== 1'b0 || mem_valid_out !== 1'b0) begin
        errs++;
        $display("FAIL cancel_hold[%0d]: allowin=%b req=%b valid=%b, need 0 0 0",
                 i, mem_allowin_out, data_req, mem_valid_out);
      end
      step();
    end
    data_data_ok = 0;
    #1;
    vecs++;
    if (mem_allowin_out !== 1'b1 || mem_valid_out !== 1'b0) begin
      errs++; $display("FAIL cancel_exit: allowin=%b valid=%b need 1 0", mem_allowin_out, mem_valid_out);
    end
  endtask

  task automatic test_exception();
    ex_valid_in = 1; ex_memop_in = 2'b01; ex_exception_in = 1; ex_ExcCode_in = 5'h04;
    ex_wbdata_in = 32'h8000_0001;
    step();
    ex_valid_in = 0; ex_exception_in = 0; ex_ExcCode_in = 0; data_addr_ok = 1;
    #1;
    vecs++;
    if (data_req !== 1'b0 || mem_valid_out !== 1'b1 || mem_exception_out !== 1'b1 ||
        mem_ExcCode_out !== 5'h04) begin
      errs++;
      $display("FAIL exc_out: req=%b valid=%b exc=%b code=%h, need 0 1 1 04",
               data_req, mem_valid_out, mem_exception_out, mem_ExcCode_out);
    end
    step();
    data_addr_ok = 0;
    #1;
    vecs++;
    if (mem_valid_out !== 1'b0 || mem_allowin_out !== 1'b1 || data_req !== 1'b0) begin
      errs++;
      $display("FAIL exc_drain: valid=%b allowin=%b req=%b, need 0 1 0", mem_valid_out, mem_allowin_out, data_req);
    end
  endtask

  task automatic test_reset_mid();
    ex_valid_in = 1; ex_memop_in = 2'b01; ex_wbdata_in = 32'h0000_2000; ex_PC_in = 32'h0000_0444;
    step();
    ex_valid_in = 0; data_addr_ok = 1;
    step();
    data_addr_ok = 0; rst_n = 0;
    step();
    rst_n = 1;
    #1;
    vecs++;
    if (mem_valid_out !== 1'b0 || mem_allowin_out !== 1'b1 || data_req !== 1'b0 || mem_PC_out !== 32'd0) begin
      errs++;
      $display("FAIL rstmid_state: valid=%b allowin=%b req=%b pc=%h, need 0 1 0 0",
               mem_valid_out, mem_allowin_out, data_req, mem_PC_out);
    end
    data_data_ok = 1; data_rdata = 32'h5555_5555;
    step();
    data_data_ok = 0; data_rdata = 0;
    #1;
    vecs++;
    if (mem_valid_out !== 1'b0 || mem_dm_data_out !== 32'd0 || mem_allowin_out !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_ignore: valid=%b dm=%h allowin=%b, need 0 0 1",
               mem_valid_out, mem_dm_data_out, mem_allowin_out);
    end
  endtask

  task automatic test_back_to_back();
    ex_valid_in = 1; ex_memop_in = 2'b00; ex_wbdata_in = 32'hAAAA_0001;
    step();
    ex_wbdata_in = 32'hAAAA_0002;
    #1;
    vecs++;
    if (mem_valid_out !== 1'b1 || mem_wbdata_out !== 32'hAAAA_0001 || mem_allowin_out !== 1'b1) begin
      errs++;
      $display("FAIL b2b_first: valid=%b wbd=%h allowin=%b, need 1 aaaa0001 1",
               mem_valid_out, mem_wbdata_out, mem_allowin_out);
    end
    step();
    ex_valid_in = 0;
    #1;
    vecs++;
    if (mem_valid_out !== 1'b1 || mem_wbdata_out !== 32'hAAAA_0002) begin
      errs++;
      $display("FAIL b2b_second: valid=%b wbd=%h, need 1 aaaa0002", mem_valid_out, mem_wbdata_out);
    end
    step();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_alu();
    test_load();
    test_load_stall();
    idle_inputs();
    test_store_cancel();
    idle_inputs();
    test_exception();
    idle_inputs();
    test_reset_mid();
    idle_inputs();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
